// File: rtl/gelato_pkg.sv
// Shared types and width constants for the Gelato frontend fetch path.
package gelato_pkg;

    localparam int unsigned GELATO_NUM_WARPS       = 8;
    localparam int unsigned GELATO_PC_WIDTH        = 32;
    localparam int unsigned GELATO_SPLIT_NUM_WIDTH = 3;

    typedef enum logic [1:0] {
        INACTIVE = 2'd0,
        READY    = 2'd1,
        PENDING  = 2'd2
    } warp_state_t;

endpackage

// File: rtl/gelato_rr_picker.sv
// Combinational round-robin first-set finder: first set bit of req at or after start, wrapping.
module gelato_rr_picker #(
    parameter int unsigned NUM_WARPS      = 8,
    parameter int unsigned WARP_NUM_WIDTH = $clog2(NUM_WARPS)
) (
    input  logic [NUM_WARPS-1:0]      req,
    input  logic [WARP_NUM_WIDTH-1:0] start,
    output logic                      found,
    output logic [WARP_NUM_WIDTH-1:0] index
);

    logic [WARP_NUM_WIDTH-1:0] cand;

    // Scan from the farthest offset back to start so the nearest hit wins; index math wraps for free.
    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int unsigned i = NUM_WARPS; i > 0; i--) begin
            cand = start + WARP_NUM_WIDTH'(i - 1);
            if (req[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/gelato_fetch_scheduler.sv
// Warp fetch scheduler: per-warp PC table with round-robin selection into a single fetch output register.
module gelato_fetch_scheduler
    import gelato_pkg::*;
#(
    parameter int unsigned NUM_WARPS       = GELATO_NUM_WARPS,
    parameter int unsigned WARP_NUM_WIDTH  = $clog2(NUM_WARPS),
    parameter int unsigned PC_WIDTH        = GELATO_PC_WIDTH,
    parameter int unsigned SPLIT_NUM_WIDTH = GELATO_SPLIT_NUM_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rdy,
    input  logic                       launch_valid,
    input  logic [WARP_NUM_WIDTH-1:0]  launch_warp,
    input  logic [PC_WIDTH-1:0]        launch_pc,
    input  logic [SPLIT_NUM_WIDTH-1:0] launch_split,
    input  logic                       resume_valid,
    input  logic [WARP_NUM_WIDTH-1:0]  resume_warp,
    input  logic [PC_WIDTH-1:0]        resume_pc,
    input  logic [SPLIT_NUM_WIDTH-1:0] resume_split,
    input  logic                       resume_exit,
    input  logic                       flush,
    output logic                       fetch_valid,
    input  logic                       fetch_ready,
    output logic [PC_WIDTH-1:0]        fetch_pc,
    output logic [WARP_NUM_WIDTH-1:0]  fetch_warp_num,
    output logic [SPLIT_NUM_WIDTH-1:0] fetch_split_table_num,
    output logic                       all_idle
);

    warp_state_t                state     [NUM_WARPS];
    logic [PC_WIDTH-1:0]        warp_pc   [NUM_WARPS];
    logic [SPLIT_NUM_WIDTH-1:0] warp_split[NUM_WARPS];
    logic [WARP_NUM_WIDTH-1:0]  rr_ptr;

    logic [NUM_WARPS-1:0]       ready_vec;
    logic                       any_active;
    logic                       pick_found;
    logic [WARP_NUM_WIDTH-1:0]  pick_index;
    logic                       load;

    always_comb begin
        ready_vec  = '0;
        any_active = 1'b0;
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            ready_vec[w] = (state[w] == READY);
            if (state[w] != INACTIVE) any_active = 1'b1;
        end
    end

    assign load     = !fetch_valid || fetch_ready;
    assign all_idle = !any_active && !fetch_valid;

    gelato_rr_picker #(
        .NUM_WARPS      (NUM_WARPS),
        .WARP_NUM_WIDTH (WARP_NUM_WIDTH)
    ) u_picker (
        .req   (ready_vec),
        .start (rr_ptr),
        .found (pick_found),
        .index (pick_index)
    );

    // Launch needs INACTIVE, resume needs PENDING and the picked warp is READY,
    // so the three per-warp updates never target the same entry in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                state[w]      <= INACTIVE;
                warp_pc[w]    <= '0;
                warp_split[w] <= '0;
            end
            rr_ptr                <= '0;
            fetch_valid           <= 1'b0;
            fetch_pc              <= '0;
            fetch_warp_num        <= '0;
            fetch_split_table_num <= '0;
        end else if (rdy) begin
            if (flush) begin
                for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                    state[w] <= INACTIVE;
                end
                rr_ptr      <= '0;
                fetch_valid <= 1'b0;
            end else begin
                for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                    if (launch_valid && launch_warp == WARP_NUM_WIDTH'(w)
                        && state[w] == INACTIVE) begin
                        state[w]      <= READY;
                        warp_pc[w]    <= launch_pc;
                        warp_split[w] <= launch_split;
                    end
                    if (resume_valid && resume_warp == WARP_NUM_WIDTH'(w)
                        && state[w] == PENDING) begin
                        state[w]      <= resume_exit ? INACTIVE : READY;
                        warp_pc[w]    <= resume_pc;
                        warp_split[w] <= resume_split;
                    end
                end
                if (load) begin
                    fetch_valid <= pick_found;
                    if (pick_found) begin
                        state[pick_index]     <= PENDING;
                        fetch_pc              <= warp_pc[pick_index];
                        fetch_warp_num        <= pick_index;
                        fetch_split_table_num <= warp_split[pick_index];
                        rr_ptr                <= pick_index + WARP_NUM_WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gelato_fetch_scheduler.sv
// Scoreboard bench for gelato_fetch_scheduler: expected fetches queued at stimulus, checked at handshake.
module tb_gelato_fetch_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        launch_valid;
    logic [2:0]  launch_warp;
    logic [31:0] launch_pc;
    logic [2:0]  launch_split;
    logic        resume_valid;
    logic [2:0]  resume_warp;
    logic [31:0] resume_pc;
    logic [2:0]  resume_split;
    logic        resume_exit;
    logic        flush;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic [2:0]  fetch_warp_num;
    logic [2:0]  fetch_split_table_num;
    logic        all_idle;

    typedef struct packed {
        logic [2:0]  warp;
        logic [31:0] pc;
        logic [2:0]  split;
    } fetch_exp_t;

    fetch_exp_t exp_q[$];
    int unsigned n_asserts = 0;
    int unsigned n_fail    = 0;

    always #5 clk = ~clk;

    gelato_fetch_scheduler #(
        .NUM_WARPS       (8),
        .PC_WIDTH        (32),
        .SPLIT_NUM_WIDTH (3)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .rdy                   (rdy),
        .launch_valid          (launch_valid),
        .launch_warp           (launch_warp),
        .launch_pc             (launch_pc),
        .launch_split          (launch_split),
        .resume_valid          (resume_valid),
        .resume_warp           (resume_warp),
        .resume_pc             (resume_pc),
        .resume_split          (resume_split),
        .resume_exit           (resume_exit),
        .flush                 (flush),
        .fetch_valid           (fetch_valid),
        .fetch_ready           (fetch_ready),
        .fetch_pc              (fetch_pc),
        .fetch_warp_num        (fetch_warp_num),
        .fetch_split_table_num (fetch_split_table_num),
        .all_idle              (all_idle)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every accepted request is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && rdy && !flush && fetch_valid && fetch_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_fetch", 32'(fetch_warp_num), 32'hffff_ffff);
            end else begin
                fetch_exp_t e;
                e = exp_q.pop_front();
                check("sb_warp", 32'(fetch_warp_num), 32'(e.warp));
                check("sb_pc", fetch_pc, e.pc);
                check("sb_split", 32'(fetch_split_table_num), 32'(e.split));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input int w, input logic [31:0] pc, input int s);
        exp_q.push_back('{warp: 3'(w), pc: pc, split: 3'(s)});
    endtask

    task automatic do_launch(input int w, input logic [31:0] pc, input int s);
        launch_valid = 1'b1;
        launch_warp  = 3'(w);
        launch_pc    = pc;
        launch_split = 3'(s);
        tick();
        launch_valid = 1'b0;
    endtask

    task automatic do_resume(input int w, input logic [31:0] pc, input int s, input logic ex);
        resume_valid = 1'b1;
        resume_warp  = 3'(w);
        resume_pc    = pc;
        resume_split = 3'(s);
        resume_exit  = ex;
        tick();
        resume_valid = 1'b0;
        resume_exit  = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_remaining", 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; fetch_ready = 1'b0;
        launch_valid = 1'b0; launch_warp = '0; launch_pc = '0; launch_split = '0;
        resume_valid = 1'b0; resume_warp = '0; resume_pc = '0; resume_split = '0;
        resume_exit = 1'b0;
        tick(); tick();
        check("rst_fetch_valid", 32'(fetch_valid), 0);
        check("rst_fetch_pc", fetch_pc, 0);
        check("rst_fetch_warp", 32'(fetch_warp_num), 0);
        check("rst_fetch_split", 32'(fetch_split_table_num), 0);
        check("rst_all_idle", 32'(all_idle), 1);
        rst_n = 1'b1;
        tick();

        // Launch-to-request latency of 2 cycles
        fetch_ready = 1'b1;
        expect_fetch(3, 32'h100, 1);
        do_launch(3, 32'h100, 1);
        check("lat_not_yet", 32'(fetch_valid), 0);
        tick();
        check("lat_valid", 32'(fetch_valid), 1);
        check("lat_pc", fetch_pc, 32'h100);
        check("lat_warp", 32'(fetch_warp_num), 3);
        tick();
        check("pending_no_reissue", 32'(fetch_valid), 0);
        check("active_not_idle", 32'(all_idle), 0);
        wait_drain(4);

        // Stalled output then round-robin issue 0,1,2
        fetch_ready = 1'b0;
        expect_fetch(0, 32'h200, 0);
        expect_fetch(1, 32'h210, 2);
        expect_fetch(2, 32'h220, 5);
        do_launch(0, 32'h200, 0);
        do_launch(1, 32'h210, 2);
        do_launch(2, 32'h220, 5);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(fetch_valid), 1);
            check("stall_pc", fetch_pc, 32'h200);
            check("stall_warp", 32'(fetch_warp_num), 0);
            tick();
        end
        fetch_ready = 1'b1;
        tick();
        check("b2b_warp1", 32'(fetch_warp_num), 1);
        check("b2b_valid1", 32'(fetch_valid), 1);
        tick();
        check("b2b_warp2", 32'(fetch_warp_num), 2);
        tick();
        check("b2b_empty", 32'(fetch_valid), 0);
        wait_drain(4);

        // Round-robin wrap: warp 3 occupies the output, then 2,1,0 resumed out of order
        fetch_ready = 1'b0;
        expect_fetch(3, 32'h330, 3);
        expect_fetch(0, 32'h300, 0);
        expect_fetch(1, 32'h310, 1);
        expect_fetch(2, 32'h320, 2);
        do_resume(3, 32'h330, 3, 1'b0);
        tick();
        do_resume(2, 32'h320, 2, 1'b0);
        do_resume(1, 32'h310, 1, 1'b0);
        do_resume(0, 32'h300, 0, 1'b0);
        check("wrap_head_warp", 32'(fetch_warp_num), 3);
        fetch_ready = 1'b1;
        wait_drain(10);

        // Exits and ignored launch/resume
        do_resume(2, 32'h0, 0, 1'b1);
        tick();
        check("exit_no_fetch", 32'(fetch_valid), 0);
        check("exit_still_active", 32'(all_idle), 0);
        do_resume(2, 32'h999, 1, 1'b0);
        tick(); tick();
        check("resume_inactive_ignored", 32'(fetch_valid), 0);
        do_launch(0, 32'hdead, 7);
        tick(); tick();
        check("launch_pending_ignored", 32'(fetch_valid), 0);
        do_resume(0, 32'h0, 0, 1'b1);
        do_resume(1, 32'h0, 0, 1'b1);
        check("idle_before_last", 32'(all_idle), 0);
        do_resume(3, 32'h0, 0, 1'b1);
        tick();
        check("all_idle_after_exit", 32'(all_idle), 1);
        check("idle_no_fetch", 32'(fetch_valid), 0);

        // Launch and resume to different warps in one cycle
        fetch_ready = 1'b0;
        expect_fetch(4, 32'h400, 4);
        expect_fetch(5, 32'h500, 5);
        expect_fetch(6, 32'h600, 6);
        expect_fetch(4, 32'h440, 2);
        do_launch(4, 32'h400, 4);
        do_launch(5, 32'h500, 5);
        launch_valid = 1'b1; launch_warp = 3'd6; launch_pc = 32'h600; launch_split = 3'd6;
        do_resume(4, 32'h440, 2, 1'b0);
        launch_valid = 1'b0;
        fetch_ready = 1'b1;
        wait_drain(10);

        // Flush against a launch and an accepted handshake
        fetch_ready = 1'b0;
        do_resume(5, 32'h550, 1, 1'b0);
        tick();
        check("preflush_valid", 32'(fetch_valid), 1);
        check("preflush_pc", fetch_pc, 32'h550);
        flush = 1'b1; fetch_ready = 1'b1;
        do_launch(7, 32'h700, 0);
        flush = 1'b0;
        check("flush_valid", 32'(fetch_valid), 0);
        check("flush_idle", 32'(all_idle), 1);
        tick(); tick(); tick();
        check("postflush_valid", 32'(fetch_valid), 0);

        // rdy low freezes everything
        rdy = 1'b0;
        do_launch(1, 32'h111, 1);
        tick();
        check("rdy_low_valid", 32'(fetch_valid), 0);
        check("rdy_low_idle", 32'(all_idle), 1);
        rdy = 1'b1;
        tick(); tick();
        check("rdy_low_no_launch", 32'(fetch_valid), 0);

        // Asynchronous reset drops a pending request
        fetch_ready = 1'b0;
        do_launch(1, 32'h1000, 2);
        tick();
        check("prereset_valid", 32'(fetch_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(fetch_valid), 0);
        check("async_rst_pc", fetch_pc, 0);
        check("async_rst_idle", 32'(all_idle), 1);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        check("post_reset_quiet", 32'(fetch_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
